// File: rtl/param_mc_pkg.sv
// ---------------------------------------------------------------------------
// param_mc_pkg
// Shared definitions for the parametrised multi-cycle processor:
//   - opcode encodings (OP_ADD .. OP_HLT); 0xA..0xE are undefined and trap
//   - FSM state enumeration
//   - instruction field bit positions
//   - helper deciding which opcodes write the register file
// ---------------------------------------------------------------------------
package param_mc_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h4;
    localparam logic [3:0] OP_B   = 4'h5;
    localparam logic [3:0] OP_BZ  = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_LDR = 4'h8;
    localparam logic [3:0] OP_STR = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes that write rd, update Z and pulse data_valid.
    function automatic logic writes_reg(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_NOT) || (op == OP_LDI) ||
               (op == OP_LDR);
    endfunction

endpackage

// File: rtl/param_mc_alu.sv
// ---------------------------------------------------------------------------
// param_mc_alu
// Combinational ALU for the multi-cycle processor.
//   op     in  4       opcode
//   a      in  DATA_W  first operand (rs value)
//   b      in  DATA_W  second operand (rt value, or preloaded immediate /
//                      memory word for LDI / LDR)
//   result out DATA_W  truncated result
//   zero   out 1       result == 0
// ---------------------------------------------------------------------------
module param_mc_alu
    import param_mc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:         result = a + b;
            OP_SUB:         result = a - b;
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_NOT:         result = ~a;
            // LDI/LDR arrive with the value to load already placed on b.
            OP_LDI, OP_LDR: result = b;
            default:        result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/param_mc_processor.sv
// ---------------------------------------------------------------------------
// param_mc_processor
// Parametrised multi-cycle processor: FETCH / DECODE / EXEC over an internal
// instruction memory (host loadable), register file and data memory.
//   clk         in  1       rising-edge clock
//   reset_n     in  1       asynchronous active-low reset
//   start       in  1       run from pc=0 (IDLE or HALT only)
//   imem_we     in  1       instruction write strobe (ignored while busy)
//   imem_addr   in  IA_W    instruction write address
//   imem_wdata  in  16      instruction word
//   busy        out 1       FETCH/DECODE/EXEC
//   halted      out 1       HALT
//   illegal     out 1       sticky undefined-opcode flag
//   pc_out      out IA_W    current pc
//   data_out    out DATA_W  last register write value
//   data_valid  out 1       one-cycle pulse per register write
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | after reset; start clears registers and begins at pc=0
// ST_FETCH  | latch imem[pc] into ir
// ST_DECODE | latch opcode / rd index and read rs, rt, rd operands
// ST_EXEC   | execute, write back, advance pc
// ST_HALT   | stopped by HLT or trap; start reruns from pc=0, keeps state
// ---------------------------------------------------------------------------
module param_mc_processor
    import param_mc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_REGS   = 4,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16,
    localparam int IA_W      = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              imem_we,
    input  logic [IA_W-1:0]   imem_addr,
    input  logic [15:0]       imem_wdata,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic [IA_W-1:0]   pc_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    localparam int DA_W = $clog2(DMEM_DEPTH);
    localparam int RI_W = $clog2(NUM_REGS);

    logic [15:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    state_t            state;
    logic [IA_W-1:0]   pc;
    logic [15:0]       ir;
    logic [3:0]        op_q;
    logic [RI_W-1:0]   rd_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] d_q;
    logic              z_flag;

    logic [3:0]        f_op;
    logic [RI_W-1:0]   f_rd;
    logic [RI_W-1:0]   f_rs;
    logic [RI_W-1:0]   f_rt;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_val;
    logic [IA_W-1:0]   pc_inc;
    logic [IA_W-1:0]   pc_br;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero;

    // Register index is the 4-bit field modulo NUM_REGS (NUM_REGS need not
    // be a power of two).
    function automatic logic [RI_W-1:0] ridx(input logic [3:0] f);
        return RI_W'(32'(f) % NUM_REGS);
    endfunction

    assign f_op   = ir[OP_MSB:OP_LSB];
    assign f_rd   = ridx(ir[RD_MSB:RD_LSB]);
    assign f_rs   = ridx(ir[RS_MSB:RS_LSB]);
    assign f_rt   = ridx(ir[RT_MSB:RT_LSB]);
    assign rs_val = regs[f_rs];
    assign pc_inc = pc + IA_W'(1);
    // IMEM_DEPTH <= 256, so adding the low IA_W bits of the 8-bit offset is
    // the same as adding sext(imm8) modulo IMEM_DEPTH.
    assign pc_br  = pc + ir[IA_W-1:0];
    assign pc_out = pc;

    // zext(imm8) truncated to DATA_W (DATA_W may be below or above 8).
    always_comb begin
        imm_ext = '0;
        for (int i = 0; i < DATA_W && i < 8; i++) begin
            imm_ext[i] = ir[IMM_LSB + i];
        end
    end

    param_mc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // Instruction memory is deliberately not reset so a loaded program
    // survives reset_n.
    always_ff @(posedge clk) begin
        if (imem_we && !busy) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pc         <= '0;
            ir         <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            d_q        <= '0;
            z_flag     <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        busy    <= 1'b1;
                        pc      <= '0;
                        illegal <= 1'b0;
                        for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        busy    <= 1'b1;
                        halted  <= 1'b0;
                        pc      <= '0;
                        illegal <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    ir    <= imem[pc];
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    op_q <= f_op;
                    rd_q <= f_rd;
                    a_q  <= rs_val;
                    d_q  <= regs[f_rd];
                    // Immediate and load data ride on the ALU b operand.
                    if (f_op == OP_LDI) begin
                        b_q <= imm_ext;
                    end else if (f_op == OP_LDR) begin
                        b_q <= dmem[rs_val[DA_W-1:0]];
                    end else begin
                        b_q <= regs[f_rt];
                    end
                    state <= ST_DECODE == ST_DECODE ? ST_EXEC : ST_EXEC;
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    if (writes_reg(op_q)) begin
                        regs[rd_q] <= alu_res;
                        z_flag     <= alu_zero;
                        data_out   <= alu_res;
                        data_valid <= 1'b1;
                        pc         <= pc_inc;
                    end else begin
                        case (op_q)
                            OP_STR: begin
                                dmem[a_q[DA_W-1:0]] <= d_q;
                                pc <= pc_inc;
                            end
                            OP_B: begin
                                pc <= pc_br;
                            end
                            OP_BZ: begin
                                pc <= z_flag ? pc_br : pc_inc;
                            end
                            OP_HLT: begin
                                state  <= ST_HALT;
                                busy   <= 1'b0;
                                halted <= 1'b1;
                            end
                            default: begin
                                // Undefined opcode: trap, pc and data untouched.
                                state   <= ST_HALT;
                                busy    <= 1'b0;
                                halted  <= 1'b1;
                                illegal <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_mc_processor.sv
module tb_param_mc_processor;

    localparam int DATA_W     = 8;
    localparam int NUM_REGS   = 4;
    localparam int IMEM_DEPTH = 16;
    localparam int DMEM_DEPTH = 16;
    localparam int MASK       = (1 << DATA_W) - 1;

    typedef logic [15:0] prog_t [IMEM_DEPTH];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_addr = '0;
    logic [15:0] imem_wdata = '0;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [3:0]  pc_out;
    logic [7:0]  data_out;
    logic        data_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    // Architectural model state (ISA level).
    int m_regs[16];
    int m_dmem[16];
    bit m_z;
    bit m_idle;

    param_mc_processor #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
        .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .halted(halted), .illegal(illegal), .pc_out(pc_out),
        .data_out(data_out), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Monitor: every data_valid pulse must match the next expected write.
    always @(negedge clk) begin
        if (reset_n && data_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got 0x%0h expected no data_valid", data_out);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(data_out) != e) begin
                    n_fail++;
                    $display("FAIL write_value: got 0x%0h expected 0x%0h", data_out, e);
                end
            end
        end
    end

    function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int rt);
        return {4'(op), 4'(rd), 4'(rs), 4'(rt)};
    endfunction

    function automatic logic [15:0] enci(input int op, input int rd, input int imm);
        return {4'(op), 4'(rd), 8'(imm)};
    endfunction

    function automatic void fill_hlt(output prog_t p);
        for (int i = 0; i < IMEM_DEPTH; i++) p[i] = 16'hF000;
    endfunction

    // Interpret a program from pc=0 per the instruction set rules.
    task automatic model_run(input prog_t p, input bit commit, output int steps,
                             output bit ok, output int fpc, output bit fill);
        int r[16]; int d[16]; bit z; int pc; int q[$];
        int op, rd, rs, rt, imm, a, b, res, sx;
        bit wr, done;
        r = m_regs; d = m_dmem; z = m_z;
        if (m_idle) for (int i = 0; i < 16; i++) r[i] = 0;
        pc = 0; steps = 0; ok = 0; fill = 0; done = 0; fpc = 0;
        while (!done && steps < 100) begin
            op  = int'(p[pc][15:12]);
            rd  = int'(p[pc][11:8]) % NUM_REGS;
            rs  = int'(p[pc][7:4]) % NUM_REGS;
            rt  = int'(p[pc][3:0]) % NUM_REGS;
            imm = int'(p[pc][7:0]);
            a = r[rs]; b = r[rt]; res = 0; wr = 0;
            steps++;
            case (op)
                0: begin res = (a + b) & MASK; wr = 1; end
                1: begin res = (a - b) & MASK; wr = 1; end
                2: begin res = a & b; wr = 1; end
                3: begin res = a | b; wr = 1; end
                4: begin res = (~a) & MASK; wr = 1; end
                7: begin res = imm & MASK; wr = 1; end
                8: begin res = d[a % DMEM_DEPTH]; wr = 1; end
                9: begin d[a % DMEM_DEPTH] = r[rd]; pc = (pc + 1) % IMEM_DEPTH; end
                5, 6: begin
                    sx = (imm >= 128) ? imm - 256 : imm;
                    if (op == 5 || z) pc = (pc + sx + 256) % IMEM_DEPTH;
                    else pc = (pc + 1) % IMEM_DEPTH;
                end
                15: begin done = 1; ok = 1; end
                default: begin done = 1; ok = 1; fill = 1; end
            endcase
            if (wr) begin
                r[rd] = res; z = (res == 0); q.push_back(res);
                pc = (pc + 1) % IMEM_DEPTH;
            end
        end
        fpc = pc;
        if (commit && ok) begin
            m_regs = r; m_dmem = d; m_z = z; m_idle = 0;
            foreach (q[i]) exp_q.push_back(q[i]);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin m_regs[i] = 0; m_dmem[i] = 0; end
        m_z = 0; m_idle = 1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load_imem(input prog_t p, input int first);
        for (int i = first; i < IMEM_DEPTH; i++) begin
            @(negedge clk);
            imem_we = 1'b1; imem_addr = 4'(i); imem_wdata = p[i];
        end
        @(negedge clk);
        imem_we = 1'b0;
    endtask

    // wr0: load word 0 in the same cycle as start (from IDLE).
    task automatic run_prog(input string tag, input prog_t p, input bit reload,
                            input bit noise, input bit wr0);
        int steps, fpc, cyc; bit ok, fill;
        model_run(p, 1'b1, steps, ok, fpc, fill);
        if (reload) load_imem(p, wr0 ? 1 : 0);
        @(negedge clk);
        start = 1'b1;
        if (wr0) begin imem_we = 1'b1; imem_addr = 4'd0; imem_wdata = p[0]; end
        @(posedge clk); #1;
        start = 1'b0; imem_we = 1'b0;
        check({tag, "_illegal_clr"}, int'(illegal), 0);
        check({tag, "_busy"}, int'(busy), 1);
        cyc = 0;
        while (!halted && cyc < 3 * steps + 20) begin
            if (noise) begin
                imem_we    = 1'($urandom);
                imem_addr  = 4'($urandom);
                imem_wdata = 16'($urandom);
                start      = ($urandom_range(0, 5) == 0);
            end
            @(posedge clk); #1;
            cyc++;
            imem_we = 1'b0; start = 1'b0;
        end
        check({tag, "_cycles"}, cyc, 3 * steps);
        check({tag, "_halted"}, int'(halted), 1);
        check({tag, "_not_busy"}, int'(busy), 0);
        check({tag, "_pc"}, int'(pc_out), fpc);
        check({tag, "_illegal"}, int'(illegal), int'(fill));
        repeat (2) @(negedge clk);
        check({tag, "_writes_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic gen_prog(output prog_t p);
        int len, k, op, steps, fpc; bit ok, fill;
        for (int t = 0; t < 40; t++) begin
            fill_hlt(p);
            len = $urandom_range(3, 12);
            for (int i = 0; i < len - 1; i++) begin
                k = $urandom_range(0, 21);
                if (k <= 9) op = k;
                else if (k <= 12) op = 7;
                else if (k <= 19) op = $urandom_range(0, 4);
                else if (k == 20) op = 15;
                else op = 10 + $urandom_range(0, 4);
                p[i] = {4'(op), 12'($urandom)};
            end
            model_run(p, 1'b0, steps, ok, fpc, fill);
            if (ok) return;
        end
        fill_hlt(p);
    endtask

    initial begin
        prog_t p;
        prog_t prev;

        do_reset();
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_pc", int'(pc_out), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_data_valid", int'(data_valid), 0);

        // LDI/LDI/ADD/HLT: writes 5, 3, 8; halts at pc 3 after 12 cycles.
        fill_hlt(p);
        p[0] = enci(7, 1, 5); p[1] = enci(7, 2, 3); p[2] = enc(0, 3, 1, 2);
        run_prog("add", p, 1'b1, 1'b0, 1'b0);

        // SUB borrow wrap, SUB to zero, BZ +2 skips one word.
        fill_hlt(p);
        p[0] = enci(7, 1, 0); p[1] = enci(7, 2, 1); p[2] = enc(1, 3, 1, 2);
        p[3] = enc(1, 3, 2, 2); p[4] = enci(6, 0, 2); p[5] = enci(7, 0, 8'h11);
        p[6] = enci(7, 0, 8'h22);
        run_prog("bz", p, 1'b1, 1'b0, 1'b0);

        // STR then LDR through dmem[2]; STR itself must not pulse data_valid.
        fill_hlt(p);
        p[0] = enci(7, 1, 8'hA5); p[1] = enci(7, 2, 2); p[2] = enc(9, 1, 2, 0);
        p[3] = enci(7, 1, 0); p[4] = enc(8, 0, 2, 0);
        run_prog("str_ldr", p, 1'b1, 1'b0, 1'b0);

        // Illegal opcode at pc=1, then registers retained into the next run.
        fill_hlt(p);
        p[0] = enci(7, 1, 7); p[1] = 16'hB123; p[2] = enci(7, 1, 9);
        run_prog("illegal", p, 1'b1, 1'b0, 1'b0);
        fill_hlt(p);
        p[0] = enc(0, 2, 1, 3);
        run_prog("retain", p, 1'b1, 1'b0, 1'b0);

        // B -1 at pc=0 wraps to 15; rerun with imem writes hammered while busy.
        fill_hlt(p);
        p[0] = enci(5, 0, 8'hFF); p[15] = enci(7, 1, 8'h3C); p[14] = 16'hF000;
        p[1] = 16'hF000;
        p[15] = 16'hF000;
        run_prog("wrap", p, 1'b1, 1'b1, 1'b0);
        run_prog("wrap_rerun", p, 1'b0, 1'b1, 1'b0);

        // Reset during DECODE of STR: async return to reset values, no write.
        do_reset();
        fill_hlt(p);
        p[0] = enci(7, 1, 8'hA5); p[1] = enci(7, 2, 2); p[2] = enc(9, 1, 2, 0);
        load_imem(p, 0);
        exp_q.push_back(8'hA5); exp_q.push_back(2);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_halted", int'(halted), 0);
        check("midrst_pc", int'(pc_out), 0);
        check("midrst_data_out", int'(data_out), 0);
        check("midrst_data_valid", int'(data_valid), 0);
        check("midrst_writes_seen", exp_q.size(), 0);
        do_reset();
        // Read dmem[2] back; word 0 is written in the same cycle as start.
        fill_hlt(p);
        p[0] = enci(7, 2, 2); p[1] = enc(8, 3, 2, 0);
        run_prog("after_rst", p, 1'b1, 1'b0, 1'b1);

        // Randomised programs, some rerun without reload under write noise.
        fill_hlt(prev);
        for (int it = 0; it < 25; it++) begin
            if (it % 3 == 2) begin
                run_prog("rand_rerun", prev, 1'b0, 1'b1, 1'b0);
            end else begin
                gen_prog(p);
                prev = p;
                run_prog("rand", p, 1'b1, 1'b1, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
